// File: rtl/freq_frame_ctrl.sv
// ============================================================================
// freq_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer in front of the frequency-domain buffer.
//
// It takes the FFT output stream (sop/eop/valid + re/im) and regenerates a
// clean write stream of exactly TOT_SIZE entries per frame. Frames alternate
// between two banks. Each complete bank is published to the downstream reader
// through full_bank. The reader hands a bank back with rd_done/rd_bank.
// A frame is dropped when both banks are still held by the reader. A frame is
// discarded (and counted in err_cnt) when it ends early or restarts.
//
// Ports
//   sink_clk    in   single clock, rising edge
//   sink_reset  in   asynchronous, active-high reset
//   in_valid    in   upstream sample valid (no backpressure)
//   in_sop      in   upstream first sample of a frame
//   in_eop      in   upstream last sample of a frame
//   in_re/in_im in   upstream sample, DATA_WIDTH two's complement
//   buf_valid   out  1-cycle write strobe per accepted sample
//   buf_sop     out  first entry of a frame
//   buf_re/im   out  sample data; holds its last value between strobes
//   buf_bank    out  bank being written, held for the whole frame
//   full_bank   out  bit b = bank b holds a published frame
//   rd_bank     in   bank the reader releases
//   rd_done     in   1-cycle release pulse for rd_bank
//   busy        out  high while a frame is being filled
//   frame_cnt   out  frames published (saturating)
//   drop_cnt    out  frames dropped for lack of a free bank (saturating)
//   err_cnt     out  frames aborted or restarted (saturating)
// ============================================================================
module freq_frame_ctrl #(
   parameter int DATA_WIDTH = 20,
   parameter int TOT_SIZE   = 1024,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  sink_clk,
   input  logic                  sink_reset,
   input  logic                  in_valid,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [DATA_WIDTH-1:0] in_re,
   input  logic [DATA_WIDTH-1:0] in_im,
   output logic                  buf_valid,
   output logic                  buf_sop,
   output logic [DATA_WIDTH-1:0] buf_re,
   output logic [DATA_WIDTH-1:0] buf_im,
   output logic                  buf_bank,
   output logic [1:0]            full_bank,
   input  logic                  rd_bank,
   input  logic                  rd_done,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   // idx must be able to count 0..TOT_SIZE
   localparam int                IDX_W    = $clog2(TOT_SIZE + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TOT_SIZE - 1);
   localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t           state;
   logic             wr_bank;    // preferred bank for the next frame
   logic [IDX_W-1:0] idx;        // entries written in the current frame

   logic             free_ok;
   logic             free_sel;
   logic [1:0]       rel_mask;
   logic [1:0]       pub_mask;
   logic             is_last;

   // Saturating increment for the statistics counters.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_WIDTH'(1);
   endfunction

   // Free-bank selection looks only at the registered full_bank, so a
   // release requested this cycle is not yet visible here.
   always_comb begin
      free_ok  = 1'b1;
      free_sel = wr_bank;
      if (!full_bank[wr_bank]) begin
         free_sel = wr_bank;
      end else if (!full_bank[~wr_bank]) begin
         free_sel = ~wr_bank;
      end else begin
         free_ok  = 1'b0;
      end
   end

   always_comb begin
      rel_mask = rd_done ? (2'b01 << rd_bank) : 2'b00;
      pub_mask = 2'b01 << buf_bank;
      // The sample accepted now is the TOT_SIZE-th one of the frame.
      is_last  = (idx == LAST_IDX);
   end

   assign busy = (state == FILL);

   always_ff @(posedge sink_clk or posedge sink_reset) begin
      if (sink_reset) begin
         state     <= IDLE;
         wr_bank   <= 1'b0;
         idx       <= '0;
         buf_valid <= 1'b0;
         buf_sop   <= 1'b0;
         buf_re    <= '0;
         buf_im    <= '0;
         buf_bank  <= 1'b0;
         full_bank <= 2'b00;
         frame_cnt <= '0;
         drop_cnt  <= '0;
         err_cnt   <= '0;
      end else begin
         buf_valid <= 1'b0;
         buf_sop   <= 1'b0;

         // Release applies every cycle; a publish below overrides this
         // assignment with the release folded in, so both take effect.
         full_bank <= full_bank & ~rel_mask;

         case (state)
            // A start of frame in DROP is treated exactly like one in IDLE.
            IDLE, DROP: begin
               if (in_valid && in_sop) begin
                  if (free_ok) begin
                     buf_bank  <= free_sel;
                     buf_valid <= 1'b1;
                     buf_sop   <= 1'b1;
                     buf_re    <= in_re;
                     buf_im    <= in_im;
                     idx       <= ONE_IDX;
                     state     <= FILL;
                  end else begin
                     drop_cnt  <= sat_inc(drop_cnt);
                     state     <= DROP;
                  end
               end
            end

            FILL: begin
               if (in_valid) begin
                  // Every accepted sample is emitted, including the one
                  // that aborts the frame.
                  buf_valid <= 1'b1;
                  buf_re    <= in_re;
                  buf_im    <= in_im;
                  if (in_sop) begin
                     // Restart in the same bank; sop outranks eop.
                     buf_sop <= 1'b1;
                     idx     <= ONE_IDX;
                     err_cnt <= sat_inc(err_cnt);
                  end else if (is_last) begin
                     // Complete frame: eop is optional here.
                     full_bank <= (full_bank & ~rel_mask) | pub_mask;
                     frame_cnt <= sat_inc(frame_cnt);
                     wr_bank   <= ~buf_bank;
                     idx       <= '0;
                     state     <= IDLE;
                  end else if (in_eop) begin
                     // Short frame: discard without publishing.
                     err_cnt <= sat_inc(err_cnt);
                     idx     <= '0;
                     state   <= IDLE;
                  end else begin
                     idx <= idx + ONE_IDX;
                  end
               end
            end

            default: begin
               idx   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_frame_ctrl.sv
// ============================================================================
// tb_freq_frame_ctrl
// ----------------------------------------------------------------------------
// Bench for freq_frame_ctrl with TOT_SIZE=8, DATA_WIDTH=20.
// A reference model tracks frames, banks and counters at the frame level.
// Every sample it expects on the buffer port is queued; a monitor on the
// falling edge pops and compares whenever buf_valid is seen.
// ============================================================================
module tb_freq_frame_ctrl;

   localparam int DW  = 20;
   localparam int TOT = 8;
   localparam int CW  = 16;

   logic          sink_clk = 1'b0;
   logic          sink_reset;
   logic          in_valid, in_sop, in_eop;
   logic [DW-1:0] in_re, in_im;
   logic          buf_valid, buf_sop, buf_bank;
   logic [DW-1:0] buf_re, buf_im;
   logic [1:0]    full_bank;
   logic          rd_bank, rd_done, busy;
   logic [CW-1:0] frame_cnt, drop_cnt, err_cnt;

   freq_frame_ctrl #(.DATA_WIDTH(DW), .TOT_SIZE(TOT), .CNT_WIDTH(CW)) dut (
      .sink_clk  (sink_clk),
      .sink_reset(sink_reset),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .in_eop    (in_eop),
      .in_re     (in_re),
      .in_im     (in_im),
      .buf_valid (buf_valid),
      .buf_sop   (buf_sop),
      .buf_re    (buf_re),
      .buf_im    (buf_im),
      .buf_bank  (buf_bank),
      .full_bank (full_bank),
      .rd_bank   (rd_bank),
      .rd_done   (rd_done),
      .busy      (busy),
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 sink_clk = ~sink_clk;

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic          sop;
      logic          bank;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   // Reference model: whether a frame is open, how many entries it has,
   // which bank it targets, and who holds each bank.
   bit   m_open, m_drop_mode;
   int   m_cnt;
   bit   m_bank, m_pref;
   bit   m_full[2];
   int   m_frame, m_drop, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_open = 0; m_drop_mode = 0; m_cnt = 0; m_bank = 0; m_pref = 0;
      m_full[0] = 0; m_full[1] = 0;
      m_frame = 0; m_drop = 0; m_err = 0;
      q.delete();
   endtask

   task automatic model_step(input bit v, sop, eop, input logic [DW-1:0] re, im,
                             input bit rdd, rdb);
      bit nf[2];
      exp_t e;
      nf = m_full;
      if (rdd) nf[rdb] = 0;
      if (v) begin
         if (!m_open && sop) begin
            // Start of frame: pick a bank that the reader does not hold.
            if (!m_full[m_pref] || !m_full[!m_pref]) begin
               m_bank = m_full[m_pref] ? !m_pref : m_pref;
               m_open = 1; m_drop_mode = 0; m_cnt = 1;
               e.re = re; e.im = im; e.sop = 1; e.bank = m_bank;
               q.push_back(e);
            end else begin
               m_drop++; m_drop_mode = 1;
            end
         end else if (m_open) begin
            e.re = re; e.im = im; e.sop = sop; e.bank = m_bank;
            q.push_back(e);
            if (sop) begin
               m_err++; m_cnt = 1;
            end else begin
               m_cnt++;
               if (m_cnt == TOT) begin
                  nf[m_bank] = 1; m_frame++; m_pref = !m_bank; m_open = 0; m_cnt = 0;
               end else if (eop) begin
                  m_err++; m_open = 0; m_cnt = 0;
               end
            end
         end
      end
      m_full = nf;
   endtask

   // One clock: drive at the falling edge, update the model at the rising
   // edge, then compare the registered status shortly after.
   task automatic cyc(input bit v, sop, eop, input logic [DW-1:0] re, im,
                      input bit rdd = 0, input bit rdb = 0);
      @(negedge sink_clk);
      in_valid = v; in_sop = sop; in_eop = eop; in_re = re; in_im = im;
      rd_done = rdd; rd_bank = rdb;
      @(posedge sink_clk);
      model_step(v, sop, eop, re, im, rdd, rdb);
      #1;
      chk("full_bank", 32'(full_bank), {30'd0, m_full[1], m_full[0]});
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
      chk("err_cnt",   32'(err_cnt),   32'(m_err));
      chk("busy",      32'(busy),      32'(m_open));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0);
   endtask

   task automatic release_bank(input bit b);
      cyc(0, 0, 0, '0, '0, 1, b);
   endtask

   // n samples re=k, im=-k (or random); eop on index eop_at (-1 = none).
   task automatic frame(input int n, input int eop_at, input bit rnd = 0);
      for (int k = 0; k < n; k++) begin
         if (rnd) cyc(1, k == 0, k == eop_at, DW'($urandom), DW'($urandom));
         else     cyc(1, k == 0, k == eop_at, DW'(k), DW'(-k));
      end
   endtask

   task automatic do_reset(input bit check_zero);
      @(negedge sink_clk);
      #1;
      sink_reset = 1;
      in_valid = 0; in_sop = 0; in_eop = 0; in_re = '0; in_im = '0;
      rd_done = 0; rd_bank = 0;
      model_reset();
      #1;
      if (check_zero) begin
         chk("rst_buf_valid", 32'(buf_valid), 0);
         chk("rst_buf_sop",   32'(buf_sop),   0);
         chk("rst_buf_re",    32'(buf_re),    0);
         chk("rst_buf_im",    32'(buf_im),    0);
         chk("rst_buf_bank",  32'(buf_bank),  0);
         chk("rst_full_bank", 32'(full_bank), 0);
         chk("rst_busy",      32'(busy),      0);
         chk("rst_frame_cnt", 32'(frame_cnt), 0);
         chk("rst_drop_cnt",  32'(drop_cnt),  0);
         chk("rst_err_cnt",   32'(err_cnt),   0);
      end
      repeat (2) @(posedge sink_clk);
      @(negedge sink_clk);
      #1;
      sink_reset = 0;
   endtask

   // Scoreboard monitor: every strobe must match the next queued sample,
   // and no queued sample may go missing.
   always @(negedge sink_clk) begin
      if (!sink_reset) begin
         if (buf_valid) begin
            if (q.size() == 0) begin
               chk("buf_valid_unexpected", 32'(buf_valid), 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("buf_re",   32'(buf_re),   32'(e.re));
               chk("buf_im",   32'(buf_im),   32'(e.im));
               chk("buf_sop",  32'(buf_sop),  32'(e.sop));
               chk("buf_bank", 32'(buf_bank), 32'(e.bank));
            end
         end else if (q.size() != 0) begin
            chk("buf_valid_missing", 32'(buf_valid), 1);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      sink_reset = 1;
      in_valid = 0; in_sop = 0; in_eop = 0; in_re = '0; in_im = '0;
      rd_done = 0; rd_bank = 0;
      model_reset();

      // 1: single good frame into bank 0
      do_reset(1);
      frame(TOT, TOT - 1);
      idle(1);
      chk("t1_full_bank", 32'(full_bank), 32'h1);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'h1);

      // 2: fill both banks, drop the third, release bank 0, refill it
      do_reset(0);
      frame(TOT, TOT - 1);
      frame(TOT, TOT - 1);
      idle(1);
      chk("t2_full_bank", 32'(full_bank), 32'h3);
      frame(TOT, TOT - 1);
      idle(1);
      chk("t2_drop_cnt", 32'(drop_cnt), 32'h1);
      release_bank(0);
      frame(TOT, TOT - 1);
      idle(1);
      chk("t2_full_after", 32'(full_bank), 32'h3);
      chk("t2_frame_cnt",  32'(frame_cnt), 32'h3);

      // 3: early eop on the 5th sample, then a good frame
      do_reset(0);
      frame(5, 4);
      idle(1);
      chk("t3_err_cnt",   32'(err_cnt),   32'h1);
      chk("t3_full_bank", 32'(full_bank), 32'h0);
      chk("t3_busy",      32'(busy),      32'h0);
      frame(TOT, TOT - 1);
      idle(1);
      chk("t3_full_after", 32'(full_bank), 32'h1);

      // 4: sop on the 4th sample restarts; 8 entries from the restart
      do_reset(0);
      frame(3, -1);
      frame(TOT - 1, -1);
      chk("t4_not_yet", 32'(full_bank), 32'h0);
      cyc(1, 0, 0, DW'(7), DW'(-7));
      idle(1);
      chk("t4_err_cnt",   32'(err_cnt),   32'h1);
      chk("t4_full_bank", 32'(full_bank), 32'h1);

      // 5: reset in the middle of a frame
      do_reset(0);
      frame(3, -1);
      do_reset(1);
      idle(2);

      // 6: publish bank 1 while releasing bank 0; release an empty bank
      frame(TOT, TOT - 1);
      for (int k = 0; k < TOT; k++)
         cyc(1, k == 0, k == TOT - 1, DW'(k), DW'(-k), k == TOT - 1, 0);
      idle(1);
      chk("t6_both", 32'(full_bank), 32'h2);
      release_bank(0);
      idle(1);
      chk("t6_empty_rel", 32'(full_bank), 32'h2);

      // Random: well-formed frames with gaps and random releases
      do_reset(0);
      for (int f = 0; f < 12; f++) begin
         frame(TOT, ($urandom % 2) ? TOT - 1 : -1, 1);
         for (int g = $urandom_range(0, 3); g > 0; g--)
            cyc(0, 0, 0, '0, '0, ($urandom % 3) == 0, 1'($urandom));
      end

      // Random: unstructured traffic
      for (int i = 0; i < 400; i++)
         cyc(($urandom % 4) != 0, ($urandom % 10) == 0, ($urandom % 12) == 0,
             DW'($urandom), DW'($urandom), ($urandom % 10) == 0, 1'($urandom));

      idle(3);
      chk("queue_drained", 32'(q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
